// File: rtl/hbridge_pwm_dt_ctrl.sv
// hbridge_pwm_dt_ctrl: full-bridge gate controller with a period-aligned PWM
// counter, period-boundary duty reload, dead-time insertion and latched fault.
// Optional macro FBC_SLEW_LIMIT_EN: duty ramps by at most SLEW_STEP per reload,
// and polarity reversals ramp through zero before dead time is taken.
module hbridge_pwm_dt_ctrl #(
  parameter int VAL_W     = 11,
  parameter int DEAD_TIME = 5000,
  parameter int SLEW_STEP = 8
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_en,
  input  logic [VAL_W-1:0] i_signed_val,
  input  logic             i_fault,
  input  logic             i_fault_clr,
  output logic             o_TrPL,
  output logic             o_TrNL,
  output logic             o_TrPR,
  output logic             o_TrNR,
  output logic             o_fault,
  output logic             o_period_start,
  output logic [2:0]       o_state
);

  localparam int CW = VAL_W - 1;
  localparam int DW = (DEAD_TIME > 1) ? $clog2(DEAD_TIME) : 1;
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [DW-1:0] DT_LAST = DW'(DEAD_TIME - 1);
  localparam logic [CW-1:0] STEP    = CW'(SLEW_STEP);
`ifdef FBC_SLEW_LIMIT_EN
  localparam bit SLEW_ON = 1'b1;
`else
  localparam bit SLEW_ON = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DEAD  = 3'd1,
    S_POS   = 3'd2,
    S_NEG   = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_duty;
  logic [DW-1:0] r_dcnt;
  logic          r_TrPL, r_TrNL, r_TrPR, r_TrNR;
  logic          r_fault;
  logic          r_ps;

  // command magnitude; the most-negative code has no positive twin, so saturate
  logic          w_neg;
  logic          w_min;
  logic [CW-1:0] w_negv;
  logic [CW-1:0] w_mag;

  assign w_neg  = i_signed_val[VAL_W-1];
  assign w_min  = w_neg && (i_signed_val[CW-1:0] == '0);
  assign w_negv = ~i_signed_val[CW-1:0] + CW'(1);
  assign w_mag  = !w_neg ? i_signed_val[CW-1:0] : (w_min ? '1 : w_negv);

  // reload decision: new duty and whether the reload turns into a reversal
  logic          w_opp;
  logic          w_rl_dead;
  logic [CW-1:0] w_rl_duty;
  logic [CW-1:0] w_entry_duty;
  logic [CW-1:0] w_up, w_dn;

  assign w_opp = (r_state == S_POS) ? w_neg : !w_neg;
  assign w_up  = w_mag - r_duty;
  assign w_dn  = r_duty - w_mag;

  // with slewing the applied duty walks toward the command; reversal waits for zero
  always_comb begin
    w_rl_dead    = w_opp;
    w_rl_duty    = w_mag;
    w_entry_duty = w_mag;
    if (SLEW_ON) begin
      w_entry_duty = '0;
      if (w_opp) begin
        w_rl_dead = (r_duty == '0);
        w_rl_duty = (r_duty > STEP) ? r_duty - STEP : '0;
      end else if (w_mag > r_duty) begin
        w_rl_duty = (w_up > STEP) ? r_duty + STEP : w_mag;
      end else begin
        w_rl_duty = (w_dn > STEP) ? r_duty - STEP : w_mag;
      end
    end
  end

  // next-state: fault > disable > sign change > duty reload
  state_t        w_nstate;
  logic [CW-1:0] w_ncnt;
  logic [CW-1:0] w_nduty;
  logic [DW-1:0] w_ndcnt;

  always_comb begin
    w_nstate = r_state;
    w_ncnt   = r_cnt;
    w_nduty  = r_duty;
    w_ndcnt  = r_dcnt;
    if (i_fault) begin
      w_nstate = S_FAULT;
      w_ncnt   = '0;
      w_nduty  = '0;
      w_ndcnt  = '0;
    end else if (r_state == S_FAULT) begin
      if (i_fault_clr) w_nstate = S_IDLE;
    end else if (!i_en) begin
      w_nstate = S_IDLE;
      w_ncnt   = '0;
      w_nduty  = '0;
      w_ndcnt  = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_nstate = S_DEAD;
          w_ndcnt  = '0;
        end
        S_DEAD: begin
          if (r_dcnt == DT_LAST) begin
            w_nstate = w_neg ? S_NEG : S_POS;
            w_ncnt   = '0;
            w_nduty  = w_entry_duty;
            w_ndcnt  = '0;
          end else begin
            w_ndcnt  = r_dcnt + DW'(1);
          end
        end
        S_POS, S_NEG: begin
          if (r_cnt == CNT_MAX) begin
            w_ncnt = '0;
            if (w_rl_dead) begin
              w_nstate = S_DEAD;
              w_nduty  = '0;
              w_ndcnt  = '0;
            end else begin
              w_nduty  = w_rl_duty;
            end
          end else begin
            w_ncnt = r_cnt + CW'(1);
          end
        end
        default: w_nstate = S_IDLE;
      endcase
    end
  end

  // state, counters and gate/status outputs all registered from next values
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_duty  <= '0;
      r_dcnt  <= '0;
      r_TrPL  <= 1'b0;
      r_TrNL  <= 1'b0;
      r_TrPR  <= 1'b0;
      r_TrNR  <= 1'b0;
      r_fault <= 1'b0;
      r_ps    <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_cnt   <= w_ncnt;
      r_duty  <= w_nduty;
      r_dcnt  <= w_ndcnt;
      r_TrPL  <= (w_nstate == S_POS) && (w_ncnt < w_nduty);
      r_TrNR  <= (w_nstate == S_POS);
      r_TrPR  <= (w_nstate == S_NEG) && (w_ncnt < w_nduty);
      r_TrNL  <= (w_nstate == S_NEG);
      r_fault <= (w_nstate == S_FAULT);
      r_ps    <= ((w_nstate == S_POS) || (w_nstate == S_NEG)) && (w_ncnt == '0);
    end
  end

  assign o_TrPL         = r_TrPL;
  assign o_TrNL         = r_TrNL;
  assign o_TrPR         = r_TrPR;
  assign o_TrNR         = r_TrNR;
  assign o_fault        = r_fault;
  assign o_period_start = r_ps;
  assign o_state        = r_state;

endmodule

// File: tb/tb_hbridge_pwm_dt_ctrl.sv
// Bench for hbridge_pwm_dt_ctrl (VAL_W=11, DEAD_TIME=4). Expected values are
// queued as stimulus is applied and popped as the matching observation is made.
module tb_hbridge_pwm_dt_ctrl;

  localparam int PER = 1024;

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic        i_en;
  logic [10:0] i_signed_val;
  logic        i_fault;
  logic        i_fault_clr;
  logic        o_TrPL, o_TrNL, o_TrPR, o_TrNR;
  logic        o_fault, o_period_start;
  logic [2:0]  o_state;

  hbridge_pwm_dt_ctrl #(.VAL_W(11), .DEAD_TIME(4), .SLEW_STEP(8)) u_dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_en(i_en), .i_signed_val(i_signed_val),
    .i_fault(i_fault), .i_fault_clr(i_fault_clr),
    .o_TrPL(o_TrPL), .o_TrNL(o_TrNL), .o_TrPR(o_TrPR), .o_TrNR(o_TrNR),
    .o_fault(o_fault), .o_period_start(o_period_start), .o_state(o_state)
  );

  always #5 i_clk = ~i_clk;

  typedef struct { string tag; int val; } exp_t;
  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_ovl   = 0;

  // gate pairs on one leg must never conduct together
  always @(negedge i_clk)
    if ((o_TrPL && o_TrNL) || (o_TrPR && o_TrNR)) n_ovl++;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input int v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input int obs);
    exp_t e;
    if (sb.size() == 0) chk("sb_underflow", 1, 0);
    else begin
      e = sb.pop_front();
      chk(e.tag, obs, e.val);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  function automatic int gates();
    return int'(o_TrPL) + int'(o_TrNL) + int'(o_TrPR) + int'(o_TrNR);
  endfunction

  // one full period from its first clock; optional mid-period command change
  task automatic measure(input int chg_at, input int chg_val,
                         output int pl, output int pr, output int nl, output int nr);
    pl = 0; pr = 0; nl = 0; nr = 0;
    for (int i = 0; i < PER; i++) begin
      if (i == chg_at) i_signed_val = 11'(chg_val);
      pl += int'(o_TrPL); pr += int'(o_TrPR);
      nl += int'(o_TrNL); nr += int'(o_TrNR);
      tick();
    end
  endtask

  // length of the DEAD stretch starting now, and any gate activity within it
  task automatic count_dead(output int n, output int gon);
    n = 0; gon = 0;
    while (o_state == 3'd1 && n < 64) begin
      n++;
      gon += gates();
      tick();
    end
  endtask

  int pl, pr, nl, nr, n, gon;

  initial begin
    i_reset_n = 1'b0; i_en = 1'b0; i_signed_val = '0; i_fault = 1'b0; i_fault_clr = 1'b0;
    #12;
    push("rst_state", 0); push("rst_gates", 0); push("rst_fault", 0); push("rst_ps", 0);
    pop_chk(int'(o_state)); pop_chk(gates()); pop_chk(int'(o_fault)); pop_chk(int'(o_period_start));
    @(negedge i_clk);
    i_reset_n = 1'b1;
    push("idle_hold", 0);
    tick();
    pop_chk(int'(o_state));

`ifndef FBC_SLEW_LIMIT_EN
    // startup at +256
    i_en = 1'b1; i_signed_val = 11'(256);
    push("start_dead", 1); push("start_dead_len", 4); push("start_dead_gates", 0);
    push("start_pos", 2); push("start_ps", 1);
    push("p256_pl", 256); push("p256_nr", PER); push("p256_pr", 0); push("p256_nl", 0);
    tick();
    pop_chk(int'(o_state));
    count_dead(n, gon); pop_chk(n); pop_chk(gon);
    pop_chk(int'(o_state)); pop_chk(int'(o_period_start));
    measure(-1, 0, pl, pr, nl, nr); pop_chk(pl); pop_chk(nr); pop_chk(pr); pop_chk(nl);

    // reversal to -300 mid-period
    push("rev_cur_pl", 256); push("rev_dead", 1); push("rev_dead_len", 4); push("rev_dead_gates", 0);
    push("rev_neg", 3); push("rev_ps", 1); push("m300_pr", 300); push("m300_nl", PER); push("m300_pl", 0);
    measure(500, -300, pl, pr, nl, nr); pop_chk(pl);
    pop_chk(int'(o_state));
    count_dead(n, gon); pop_chk(n); pop_chk(gon);
    pop_chk(int'(o_state)); pop_chk(int'(o_period_start));
    measure(-1, 0, pl, pr, nl, nr); pop_chk(pr); pop_chk(nl); pop_chk(pl);

    // saturation of the most-negative code
    push("sat_cur_pr", 300); push("sat_pr", 1023); push("sat_nl", PER);
    measure(10, -1024, pl, pr, nl, nr); pop_chk(pr);
    measure(-1, 0, pl, pr, nl, nr); pop_chk(pr); pop_chk(nl);

    // zero command counts as positive and gives no high-side pulse
    push("z_cur_pr", 1023); push("z_dead_len", 4); push("z_pos", 2);
    push("z_pl", 0); push("z_nr", PER);
    measure(10, 0, pl, pr, nl, nr); pop_chk(pr);
    count_dead(n, gon); pop_chk(n);
    pop_chk(int'(o_state));
    measure(-1, 0, pl, pr, nl, nr); pop_chk(pl); pop_chk(nr);
`else
    // slew: ramp up from zero, then reverse through zero
    i_en = 1'b1; i_signed_val = '0;
    push("s_dead_len", 4); push("s_pos", 2);
    tick();
    count_dead(n, gon); pop_chk(n);
    pop_chk(int'(o_state));
    i_signed_val = 11'(64);
    for (int k = 0; k <= 8; k++) push($sformatf("s_up%0d", k), 8 * k);
    for (int k = 0; k <= 8; k++) begin measure(-1, 0, pl, pr, nl, nr); pop_chk(pl); end
    i_signed_val = 11'(-64);
    for (int k = 0; k <= 8; k++) push($sformatf("s_dn%0d", k), 64 - 8 * k);
    for (int k = 0; k <= 8; k++) begin measure(-1, 0, pl, pr, nl, nr); pop_chk(pl); end
    push("s_rev_dead_len", 4); push("s_neg", 3); push("s_neg0", 0); push("s_neg1", 8);
    count_dead(n, gon); pop_chk(n);
    pop_chk(int'(o_state));
    measure(-1, 0, pl, pr, nl, nr); pop_chk(pr);
    measure(-1, 0, pl, pr, nl, nr); pop_chk(pr);
`endif

    // latched fault with clear handshake
    i_signed_val = 11'(256);
    for (int i = 0; i < 100; i++) tick();
    push("flt_state", 4); push("flt_gates", 0); push("flt_o", 1);
    push("flt_clr_ign", 4); push("flt_clr_ign_o", 1); push("flt_hold", 4);
    push("flt_exit", 0); push("flt_exit_o", 0); push("flt_dead", 1);
    push("flt_dead_len", 4); push("flt_pos", 2);
    i_fault = 1'b1; tick();
    pop_chk(int'(o_state)); pop_chk(gates()); pop_chk(int'(o_fault));
    i_fault_clr = 1'b1; tick();
    pop_chk(int'(o_state)); pop_chk(int'(o_fault));
    i_fault = 1'b0; i_fault_clr = 1'b0; tick();
    pop_chk(int'(o_state));
    i_fault_clr = 1'b1; tick();
    pop_chk(int'(o_state)); pop_chk(int'(o_fault));
    i_fault_clr = 1'b0; tick();
    pop_chk(int'(o_state));
    count_dead(n, gon); pop_chk(n);
    pop_chk(int'(o_state));

    // disable while running and while in DEAD
    push("dis_run", 0); push("dis_run_gates", 0); push("dis_dead_st", 1);
    push("dis_dead", 0); push("dis_dead_gates", 0); push("dis_dead_len", 4); push("dis_pos", 2);
    i_en = 1'b0; tick();
    pop_chk(int'(o_state)); pop_chk(gates());
    i_en = 1'b1; tick(); tick(); tick();
    pop_chk(int'(o_state));
    i_en = 1'b0; tick();
    pop_chk(int'(o_state)); pop_chk(gates());
    i_en = 1'b1; tick();
    count_dead(n, gon); pop_chk(n);
    pop_chk(int'(o_state));

    // async reset mid-period
    push("pre_rst_nr", 1); push("arst_gates", 0); push("arst_state", 0);
    push("arst_dead_len", 4); push("arst_pos", 2); push("arst_ps", 1);
    for (int i = 0; i < 10; i++) tick();
    pop_chk(int'(o_TrNR));
    #3 i_reset_n = 1'b0;
    #1;
    pop_chk(gates()); pop_chk(int'(o_state));
    #2 i_reset_n = 1'b1;
    tick();
    count_dead(n, gon); pop_chk(n);
    pop_chk(int'(o_state)); pop_chk(int'(o_period_start));

    chk("gate_overlap", n_ovl, 0);
    chk("sb_drain", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
